// File: rtl/ftdi_tx_arbiter.sv
// Round-robin arbiter and framer sharing one FTDI 245-FIFO send stream among N_CH byte sources.
// Each grant emits a header (8'hA0|channel), up to MAX_BURST payload bytes, then a byte-count trailer.
module ftdi_tx_arbiter #(
  parameter int N_CH      = 4,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   s_valid,
  output logic [N_CH-1:0]   s_ready,
  input  logic [8*N_CH-1:0] s_data,
  input  logic [N_CH-1:0]   s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [7:0]        m_data,
  output logic [N_CH-1:0]   grant,
  output logic              busy
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW:0] MAXB = (CW + 1)'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, TRAIL} state_e;

  state_e          state_q, state_d;
  logic [3:0]      rr_ptr_q, rr_ptr_d;
  logic [3:0]      gch_q, gch_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_CH-1:0] grant_q, grant_d;

  logic            sel_valid, sel_last;
  logic [7:0]      sel_data;
  logic            pick_found;
  logic [3:0]      pick_ch;
  logic [N_CH-1:0] pick_onehot;
  logic [CW:0]     cnt_inc;
  logic            burst_end;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    for (int i = 0; i < N_CH; i++) begin
      if (gch_q == 4'(i)) begin
        sel_valid = s_valid[i];
        sel_last  = s_last[i];
        sel_data  = s_data[8*i +: 8];
      end
    end
  end

  // Two passes: channels above rr_ptr first, then wrap to the lowest index.
  always_comb begin
    pick_found  = 1'b0;
    pick_ch     = 4'h0;
    pick_onehot = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!pick_found && s_valid[i] && (4'(i) > rr_ptr_q)) begin
        pick_found = 1'b1;
        pick_ch    = 4'(i);
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      if (!pick_found && s_valid[i] && (4'(i) <= rr_ptr_q)) begin
        pick_found = 1'b1;
        pick_ch    = 4'(i);
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      pick_onehot[i] = (pick_ch == 4'(i));
    end
  end

  assign cnt_inc   = {1'b0, cnt_q} + 1'b1;
  assign burst_end = sel_last || (cnt_inc == MAXB);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gch_d    = gch_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    m_valid  = 1'b0;
    m_data   = 8'h00;
    s_ready  = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gch_d    = pick_ch;
          rr_ptr_d = pick_ch;
          cnt_d    = '0;
          grant_d  = pick_onehot;
          state_d  = HDR;
        end
      end
      HDR: begin
        m_valid = 1'b1;
        m_data  = 8'hA0 | {4'h0, gch_q};
        if (m_ready) begin
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        m_valid = sel_valid;
        m_data  = sel_data;
        for (int i = 0; i < N_CH; i++) begin
          s_ready[i] = (gch_q == 4'(i)) && m_ready;
        end
        if (sel_valid && m_ready) begin
          cnt_d = cnt_inc[CW-1:0];
          if (burst_end) begin
            state_d = TRAIL;
          end
        end
      end
      TRAIL: begin
        m_valid = 1'b1;
        m_data  = 8'(cnt_q);
        if (m_ready) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= 4'(N_CH - 1);
      gch_q    <= 4'h0;
      cnt_q    <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gch_q    <= gch_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_ftdi_tx_arbiter.sv
// Self-checking bench for ftdi_tx_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level framing model.
module tb_ftdi_tx_arbiter;

  localparam int N  = 4;
  localparam int MB = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] s_valid, s_ready, s_last, grant;
  logic [8*N-1:0] s_data;
  logic         m_valid, m_ready, busy;
  logic [7:0]   m_data;

  logic [0:0]   s1_valid, s1_ready, s1_last, grant1;
  logic [7:0]   s1_data, m1_data;
  logic         m1_valid, m1_ready, busy1;

  int total = 0;
  int bad   = 0;

  logic [8:0]  srcQ [N][$];
  logic [11:0] expQ[$];
  logic [11:0] obsQ[$];

  always #5 clk = ~clk;

  ftdi_tx_arbiter #(.N_CH(N), .MAX_BURST(MB)) u_dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .grant(grant), .busy(busy)
  );

  ftdi_tx_arbiter #(.N_CH(1), .MAX_BURST(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .s_valid(s1_valid), .s_ready(s1_ready), .s_data(s1_data), .s_last(s1_last),
    .m_valid(m1_valid), .m_ready(m1_ready), .m_data(m1_data),
    .grant(grant1), .busy(busy1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    rst      = 1'b1;
    s_valid  = '0;
    s_last   = '0;
    s_data   = '0;
    m_ready  = 1'b0;
    s1_valid = '0;
    s1_last  = '0;
    s1_data  = 8'h00;
    m1_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Frame model: arbitrate among non-empty channels round-robin, frame each grant.
  task automatic buildExpected();
    logic [8:0] mq [N][$];
    logic [8:0] b;
    logic [3:0] g;
    int rr, ch, c, n;
    expQ.delete();
    for (int i = 0; i < N; i++) mq[i] = srcQ[i];
    rr = N - 1;
    while (1) begin
      ch = -1;
      for (int k = 1; k <= N; k++) begin
        c = (rr + k) % N;
        if (ch < 0 && mq[c].size() > 0) ch = c;
      end
      if (ch < 0) break;
      g = 4'(1 << ch);
      expQ.push_back({g, 8'hA0 + 8'(ch)});
      n = 0;
      while (n < MB && mq[ch].size() > 0) begin
        b = mq[ch].pop_front();
        expQ.push_back({g, b[7:0]});
        n++;
        if (b[8]) break;
      end
      expQ.push_back({g, 8'(n)});
      rr = ch;
    end
  endtask

  task automatic loadMessage(input int ch, input int len, input logic [7:0] first, input bit rnd);
    for (int k = 0; k < len; k++) begin
      srcQ[ch].push_back({(k == len - 1), rnd ? 8'($urandom) : first + 8'(k)});
    end
  endtask

  // readyMode: 0 = always ready, 1 = toggle starting at 1, 2 = random.
  task automatic applyStimulus(input int readyMode, input int gapPct, input int budget,
                               output int cycles, output int firstXfer);
    logic [N-1:0] take;
    logic         prevHold, done, anyLeft;
    logic [7:0]   prevData;
    obsQ.delete();
    cycles    = 0;
    firstXfer = -1;
    done      = 1'b0;
    prevHold  = 1'b0;
    prevData  = 8'h00;
    while (!done && cycles < budget) begin
      anyLeft = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (srcQ[i].size() > 0) begin
          anyLeft          = 1'b1;
          s_valid[i]       = (grant[i] && ($urandom_range(99) < gapPct)) ? 1'b0 : 1'b1;
          s_data[8*i +: 8] = srcQ[i][0][7:0];
          s_last[i]        = srcQ[i][0][8];
        end else begin
          s_valid[i]       = 1'b0;
          s_data[8*i +: 8] = 8'h00;
          s_last[i]        = 1'b0;
        end
      end
      case (readyMode)
        0:       m_ready = 1'b1;
        1:       m_ready = ((cycles % 2) == 0);
        default: m_ready = ($urandom_range(99) < 70);
      endcase
      #1;
      if (gapPct == 0 && prevHold) begin
        checkOutput("hold_valid", m_valid, 1);
        checkOutput("hold_data", m_data, prevData);
      end
      prevHold = m_valid && !m_ready;
      prevData = m_data;
      checkOutput("s_ready_onehot", $onehot0(s_ready), 1);
      checkOutput("s_ready_granted", s_ready & ~grant, 0);
      if (m_valid && m_ready) begin
        obsQ.push_back({grant, m_data});
        if (firstXfer < 0) firstXfer = cycles;
      end
      take = s_valid & s_ready;
      if (!anyLeft && !busy) begin
        done = 1'b1;
      end else begin
        @(posedge clk);
        for (int i = 0; i < N; i++) if (take[i]) void'(srcQ[i].pop_front());
        @(negedge clk);
        cycles++;
      end
    end
    checkOutput("traffic_done", done, 1);
    s_valid = '0;
    s_last  = '0;
    s_data  = '0;
  endtask

  task automatic compareStreams(input string tag);
    int n;
    checkOutput({tag, "_len"}, obsQ.size(), expQ.size());
    n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
    for (int i = 0; i < n; i++) checkOutput({tag, "_byte"}, obsQ[i], expQ[i]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cycles, firstXfer;
    logic [7:0] d;
    logic [7:0] obs1[$];
    logic       take1;

    doReset();
    #1;
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_m_data", m_data, 0);
    checkOutput("rst_s_ready", s_ready, 0);
    checkOutput("rst_grant", grant, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst1_m_valid", m1_valid, 0);
    @(negedge clk);

    $display("[TB] single message on ch2");
    for (int i = 0; i < N; i++) srcQ[i].delete();
    srcQ[2].push_back({1'b0, 8'h11});
    srcQ[2].push_back({1'b0, 8'h22});
    srcQ[2].push_back({1'b1, 8'h33});
    buildExpected();
    applyStimulus(0, 0, 200, cycles, firstXfer);
    compareStreams("single");
    checkOutput("single_cycles", cycles, 6);
    checkOutput("single_latency", firstXfer, 1);
    checkOutput("single_busy_after", busy, 0);

    $display("[TB] contention ch0/ch1");
    doReset();
    loadMessage(0, 32, 8'h00, 1'b0);
    loadMessage(1, 32, 8'h80, 1'b0);
    buildExpected();
    applyStimulus(0, 0, 500, cycles, firstXfer);
    compareStreams("contention");
    checkOutput("contention_cycles", cycles, 4 * (MB + 3));

    $display("[TB] backpressure on ch3");
    doReset();
    loadMessage(3, 3, 8'h31, 1'b0);
    buildExpected();
    applyStimulus(1, 0, 200, cycles, firstXfer);
    compareStreams("backpressure");

    $display("[TB] gap on ch1");
    doReset();
    s_valid = 4'b0010; s_data = 32'h0000_5500; s_last = '0; m_ready = 1'b1;
    #1 checkOutput("gap_idle_valid", m_valid, 0);
    nextCycle();
    #1 checkOutput("gap_hdr", {m_valid, m_data}, {1'b1, 8'hA1});
    nextCycle();
    #1 checkOutput("gap_b0", {m_valid, m_data}, {1'b1, 8'h55});
    nextCycle();
    s_valid = '0; s_data = '0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput("gap_m_valid", m_valid, 0);
      checkOutput("gap_busy", busy, 1);
      checkOutput("gap_grant", grant, 4'b0010);
      nextCycle();
    end
    s_valid = 4'b0010; s_data = 32'h0000_6600; s_last = 4'b0010;
    #1 checkOutput("gap_b1", {m_valid, m_data}, {1'b1, 8'h66});
    nextCycle();
    s_valid = '0; s_data = '0; s_last = '0;
    #1 checkOutput("gap_trailer", {m_valid, m_data}, {1'b1, 8'h02});
    nextCycle();
    #1 checkOutput("gap_idle_after", {busy, grant}, 0);
    @(negedge clk);

    $display("[TB] reset mid-payload");
    doReset();
    s_valid = 4'b0100; s_data = 32'h0010_0000; m_ready = 1'b1;
    nextCycle();
    nextCycle();
    #1 checkOutput("rmid_b0", m_data, 8'h10);
    nextCycle();
    s_data = 32'h0011_0000;
    #1 checkOutput("rmid_b1", m_data, 8'h11);
    nextCycle();
    s_data = 32'h0012_0000;
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    s_valid = 4'b1100; s_data = 32'hC3C2_0000;
    #1;
    checkOutput("rmid_m_valid", m_valid, 0);
    checkOutput("rmid_grant", grant, 0);
    checkOutput("rmid_busy", busy, 0);
    nextCycle();
    #1;
    checkOutput("rmid_hdr", m_data, 8'hA2);
    checkOutput("rmid_hdr_grant", grant, 4'b0100);
    @(negedge clk);

    $display("[TB] random traffic");
    doReset();
    for (int i = 0; i < N; i++) begin
      srcQ[i].delete();
      for (int m = 0; m < int'($urandom_range(0, 3)); m++) begin
        loadMessage(i, int'($urandom_range(1, 40)), 8'h00, 1'b1);
      end
    end
    buildExpected();
    applyStimulus(2, 25, 20000, cycles, firstXfer);
    compareStreams("random");

    $display("[TB] MAX_BURST=1 single channel");
    doReset();
    s1_valid = 1'b1; m1_ready = 1'b1; s1_last = 1'b0;
    d = 8'h40;
    for (int c = 0; c < 12; c++) begin
      s1_data = d;
      #1;
      if (m1_valid && m1_ready) obs1.push_back(m1_data);
      take1 = s1_valid[0] && s1_ready[0];
      nextCycle();
      if (take1) d = d + 8'h01;
    end
    s1_valid = 1'b0;
    checkOutput("mb1_len", obs1.size(), 9);
    for (int f = 0; f < 3; f++) begin
      if (obs1.size() >= 3 * f + 3) begin
        checkOutput("mb1_hdr", obs1[3*f], 8'hA0);
        checkOutput("mb1_data", obs1[3*f+1], 8'h40 + 8'(f));
        checkOutput("mb1_trl", obs1[3*f+2], 8'h01);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ftdi_tx_arbiter.md
# ftdi_tx_arbiter

Round-robin arbiter and framer that shares the single USB send stream of the FTDI 245-FIFO interface among up to 16 independent byte-stream requesters. Each grant sends one framed burst on the shared stream:
- a header byte carrying the channel number,
- up to MAX_BURST payload bytes passed through from the granted requester,
- a trailer byte carrying the payload byte count.

It sits between user data sources and the itvalid/itready/itdata send port, in the same clock domain as that port.

## Interface
- N_CH, 4, number of requesters; legal range 1..16.
- MAX_BURST, 16, maximum payload bytes per grant; legal range 1..255.
- clk  in  1  single clock, also the send-port clock.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  N_CH  per-requester data valid.
- s_ready  out  N_CH  per-requester ready; at most one bit high, only for the granted channel.
- s_data  in  8*N_CH  per-requester byte; channel i is bits [8i+7:8i].
- s_last  in  N_CH  per-requester end-of-message, qualified by s_valid&s_ready.
- m_valid  out  1  to send port itvalid.
- m_ready  in  1  from send port itready.
- m_data  out  8  to send port itdata.
- grant  out  N_CH  registered one-hot current grant; 0 when idle.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, HDR, PAYLOAD, TRAIL.
- Registers:
  - rr_ptr: last granted channel, width 4.
  - gch: granted channel.
  - cnt: payload count, width clog2(MAX_BURST+1).
- IDLE:
  - m_valid=0, m_data=0, s_ready=0.
  - If any s_valid bit is set, select the first set channel searching rr_ptr+1, rr_ptr+2, … modulo N_CH.
  - Register it into gch/grant, set rr_ptr=gch, clear cnt, go to HDR.
  - If no s_valid bit is set, stay in IDLE.
- HDR:
  - m_valid=1, m_data=8'hA0|gch, s_ready=0.
  - On m_ready go to PAYLOAD.
- PAYLOAD (combinational pass-through):
  - m_valid=s_valid[gch], m_data=s_data[gch], s_ready[gch]=m_ready; all other s_ready bits 0.
  - Each transfer (s_valid[gch]&m_ready) increments cnt.
  - The burst ends on the transfer where s_last[gch]=1 or cnt+1==MAX_BURST; go to TRAIL.
  - If s_valid[gch] drops mid-burst, hold PAYLOAD with m_valid=0 indefinitely. There is no timeout and no re-arbitration.
- TRAIL:
  - m_valid=1, m_data=cnt (payload bytes in the burst, 1..MAX_BURST), s_ready=0.
  - On m_ready go to IDLE and clear grant.
- A message longer than MAX_BURST is split across several grants. The continuation is re-arbitrated like any other request, so other channels may interleave.
- Header and trailer bytes stay stable while m_valid=1 and m_ready=0.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=N_CH-1 (channel 0 has first priority after reset).
  - grant=0, busy=0, cnt=0, m_valid=0, m_data=0, s_ready=0.
- Reset asserted mid-burst: the next cycle is IDLE with all outputs at reset values. The partial frame is abandoned with no trailer.
- Latency:
  - First s_valid to header on m_valid is 1 cycle (arbitration in IDLE).
  - Payload adds 0 cycles (combinational path s_valid/s_data/m_ready to m_valid/m_data/s_ready).
- Throughput with m_ready held at 1: a burst of K payload bytes occupies K+3 cycles (IDLE, HDR, K×PAYLOAD, TRAIL).
- Simultaneous s_last and cnt+1==MAX_BURST: a single transition to TRAIL; trailer = MAX_BURST.
- A channel whose s_valid rises during another channel's burst waits until IDLE. At the next arbitration, channels after rr_ptr win over earlier ones.
- N_CH=1: header is always 8'hA0; rr logic degenerates to a constant.

## Test plan
- Single message, N_CH=4, MAX_BURST=16, m_ready=1: ch2 sends 0x11,0x22,0x33 with s_last on 0x33 -> m_data sequence A2,11,22,33,03; grant=4'b0100 from HDR through TRAIL; busy returns low after TRAIL.
- Contention: ch0 and ch1 valid continuously with no s_last after reset -> frames alternate A0,16 bytes,10 then A1,16 bytes,10 then A0…; s_ready is never high for the non-granted channel.
- Backpressure: m_ready toggling 1,0,1,0 during a 3-byte ch3 message -> header A3 and trailer 03 are held stable while m_ready=0; exactly 5 output transfers; no duplicated or lost payload byte.
- Gap: ch1 sends byte 0x55, drops s_valid for 5 cycles, then sends 0x66 with s_last -> m_valid=0 during the gap; state stays PAYLOAD; output A1,55,66,02.
- Reset mid-PAYLOAD after 2 bytes of ch2 -> next cycle m_valid=0, grant=0, busy=0. If ch2 and ch3 are then both valid, ch0-first priority search selects ch2 and the first output is A2.
- MAX_BURST=1, ch0 valid continuously -> repeating frames A0,xx,01 with ch0 data incrementing by one per frame.
